mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 212 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with per-class datapath controls, retire/illegal pulses and a retire counter.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [4:0]  rt,
    input  logic        Zero,
    input  logic        rs_nz,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUsrc,
    output logic        RegDst,
    output logic        sign,
    output logic        Branch,
    output logic        PCj,
    output logic        jalsave,
    output logic        jr,
    output logic        BNEZALC,
    output logic [2:0]  ALUControl,
    output logic [2:0]  state,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW,
        C_BEQ, C_J, C_JAL, C_BNEZALC, C_ILL
    } class_t;

    state_t      state_reg, state_next;
    class_t      class_reg, dec_class, cur_class;
    logic [31:0] retired_cnt_reg;

    always_comb begin
        dec_class = C_ILL;
        case (op)
            6'h00: begin
                case (func)
                    6'h21:   dec_class = C_ADDU;
                    6'h23:   dec_class = C_SUBU;
                    6'h08:   dec_class = C_JR;
                    6'h00:   dec_class = C_NOP;
                    default: dec_class = C_ILL;
                endcase
            end
            6'h0d:   dec_class = C_ORI;
            6'h0f:   dec_class = C_LUI;
            6'h23:   dec_class = C_LW;
            6'h2b:   dec_class = C_SW;
            6'h04:   dec_class = C_BEQ;
            6'h02:   dec_class = C_J;
            6'h03:   dec_class = C_JAL;
            6'h18:   dec_class = (rt == 5'd0) ? C_BNEZALC : C_ILL;
            default: dec_class = C_ILL;
        endcase
    end

    // The live decode is only trusted in DECODE; afterwards the latched class drives.
    assign cur_class = (state_reg == S_DECODE) ? dec_class : class_reg;

    always_comb begin
        state_next = S_FETCH;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUsrc     = 1'b0;
        RegDst     = 1'b0;
        sign       = 1'b0;
        Branch     = 1'b0;
        PCj        = 1'b0;
        jalsave    = 1'b0;
        jr         = 1'b0;
        BNEZALC    = 1'b0;
        ALUControl = 3'b000;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (cur_class == C_NOP || cur_class == C_ILL) begin
                    retire     = 1'b1;
                    illegal    = (cur_class == C_ILL);
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cur_class)
                    C_ADDU: state_next = S_WB;
                    C_SUBU: begin
                        ALUControl = 3'b001;
                        state_next = S_WB;
                    end
                    C_ORI: begin
                        ALUsrc     = 1'b1;
                        ALUControl = 3'b010;
                        state_next = S_WB;
                    end
                    C_LUI: begin
                        ALUsrc     = 1'b1;
                        ALUControl = 3'b011;
                        state_next = S_WB;
                    end
                    C_LW, C_SW: begin
                        ALUsrc     = 1'b1;
                        sign       = 1'b1;
                        state_next = S_MEM;
                    end
                    C_BEQ: begin
                        Branch     = 1'b1;
                        ALUControl = 3'b001;
                        PCWrite    = Zero;
                        retire     = 1'b1;
                    end
                    C_J, C_JAL: begin
                        PCj      = 1'b1;
                        PCWrite  = 1'b1;
                        jalsave  = (cur_class == C_JAL);
                        RegWrite = (cur_class == C_JAL);
                        retire   = 1'b1;
                    end
                    C_JR: begin
                        jr      = 1'b1;
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                    end
                    C_BNEZALC: begin
                        BNEZALC  = 1'b1;
                        sign     = 1'b1;
                        PCWrite  = rs_nz;
                        RegWrite = rs_nz;
                        retire   = 1'b1;
                    end
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cur_class == C_SW) begin
                    MemWrite = 1'b1;
                    retire   = 1'b1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (cur_class == C_ADDU || cur_class == C_SUBU);
                MemtoReg = (cur_class == C_LW);
                retire   = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset masks every enable so an aborted instruction writes nothing.
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            ALUsrc     = 1'b0;
            RegDst     = 1'b0;
            sign       = 1'b0;
            Branch     = 1'b0;
            PCj        = 1'b0;
            jalsave    = 1'b0;
            jr         = 1'b0;
            BNEZALC    = 1'b0;
            ALUControl = 3'b000;
            retire     = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_FETCH;
            class_reg       <= C_NOP;
            retired_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                class_reg <= dec_class;
            if (retire)
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
        end
    end

    assign state       = state_reg;
    assign retired_cnt = retired_cnt_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle
// and checks state, packed controls, retire/illegal and the retire counter.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, func;
    logic [4:0]  rt;
    logic        Zero, rs_nz;
    logic        IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, ALUsrc, RegDst;
    logic        sign, Branch, PCj, jalsave, jr, BNEZALC;
    logic [2:0]  ALUControl, state;
    logic        retire, illegal;
    logic [31:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] IRW  = 16'h8000, PCW = 16'h4000, RW  = 16'h2000, MW  = 16'h1000;
    localparam logic [15:0] M2R  = 16'h0800, ASRC = 16'h0400, RDST = 16'h0200, SGN = 16'h0100;
    localparam logic [15:0] BR   = 16'h0080, PJ  = 16'h0040, JLS = 16'h0020, JRB = 16'h0010;
    localparam logic [15:0] BNZ  = 16'h0008, A_SUB = 16'h0001, A_OR = 16'h0002, A_LUI = 16'h0003;

    logic [15:0] ctrl;
    assign ctrl = {IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, ALUsrc, RegDst,
                   sign, Branch, PCj, jalsave, jr, BNEZALC, ALUControl};

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .rt(rt), .Zero(Zero), .rs_nz(rs_nz),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUsrc(ALUsrc), .RegDst(RegDst), .sign(sign), .Branch(Branch),
        .PCj(PCj), .jalsave(jalsave), .jr(jr), .BNEZALC(BNEZALC), .ALUControl(ALUControl),
        .state(state), .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample one cycle (1 time unit after the falling edge) then move to the next falling edge.
    task automatic step(input string tag, input logic [2:0] st, input logic [15:0] c,
                        input logic ret, input logic ill);
        #1;
        chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
        chk({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, c});
        chk({tag, ".retire"}, {31'd0, retire}, {31'd0, ret});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill});
        $display("step %s state=%0d ctrl=%04h retire=%0b illegal=%0b cnt=%0d",
                 tag, state, ctrl, retire, illegal, retired_cnt);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                             input logic z, input logic nz);
        op = o; func = f; rt = r; Zero = z; rs_nz = nz;
    endtask

    initial begin
        reset = 1'b1;
        set_instr(6'h00, 6'h00, 5'd0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.state", {29'd0, state}, 32'd0);
        chk("rst.ctrl", {16'd0, ctrl}, 32'd0);
        chk("rst.retire", {31'd0, retire}, 32'd0);
        chk("rst.cnt", retired_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_instr(6'h00, 6'h21, 5'd0, 1'b0, 1'b0);
        step("addu.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("addu.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("addu.E", 3'd2, 16'h0, 1'b0, 1'b0);
        step("addu.W", 3'd4, RW | RDST, 1'b1, 1'b0);
        chk("addu.cnt", retired_cnt, 32'd1);

        set_instr(6'h00, 6'h23, 5'd0, 1'b0, 1'b0);
        step("subu.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("subu.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("subu.E", 3'd2, A_SUB, 1'b0, 1'b0);
        step("subu.W", 3'd4, RW | RDST, 1'b1, 1'b0);

        // Opcode changes after DECODE must not disturb the latched class.
        set_instr(6'h0d, 6'h00, 5'd0, 1'b0, 1'b0);
        step("ori.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("ori.D", 3'd1, 16'h0, 1'b0, 1'b0);
        op = 6'h2b;
        step("ori.E", 3'd2, ASRC | A_OR, 1'b0, 1'b0);
        step("ori.W", 3'd4, RW, 1'b1, 1'b0);

        set_instr(6'h0f, 6'h00, 5'd0, 1'b0, 1'b0);
        step("lui.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("lui.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("lui.E", 3'd2, ASRC | A_LUI, 1'b0, 1'b0);
        step("lui.W", 3'd4, RW, 1'b1, 1'b0);

        set_instr(6'h23, 6'h00, 5'd0, 1'b0, 1'b0);
        step("lw.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("lw.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("lw.E", 3'd2, ASRC | SGN, 1'b0, 1'b0);
        step("lw.M", 3'd3, 16'h0, 1'b0, 1'b0);
        step("lw.W", 3'd4, RW | M2R, 1'b1, 1'b0);

        set_instr(6'h2b, 6'h00, 5'd0, 1'b0, 1'b0);
        step("sw.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("sw.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("sw.E", 3'd2, ASRC | SGN, 1'b0, 1'b0);
        step("sw.M", 3'd3, MW, 1'b1, 1'b0);

        set_instr(6'h04, 6'h00, 5'd0, 1'b0, 1'b0);
        step("beq0.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("beq0.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("beq0.E", 3'd2, BR | A_SUB, 1'b1, 1'b0);

        set_instr(6'h04, 6'h00, 5'd0, 1'b1, 1'b0);
        step("beq1.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("beq1.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("beq1.E", 3'd2, PCW | BR | A_SUB, 1'b1, 1'b0);

        set_instr(6'h02, 6'h00, 5'd0, 1'b0, 1'b0);
        step("j.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("j.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("j.E", 3'd2, PJ | PCW, 1'b1, 1'b0);

        set_instr(6'h03, 6'h00, 5'd0, 1'b0, 1'b0);
        step("jal.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("jal.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("jal.E", 3'd2, PJ | PCW | JLS | RW, 1'b1, 1'b0);

        set_instr(6'h00, 6'h08, 5'd0, 1'b0, 1'b0);
        step("jr.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("jr.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("jr.E", 3'd2, JRB | PCW, 1'b1, 1'b0);

        set_instr(6'h18, 6'h00, 5'd0, 1'b0, 1'b1);
        step("bnz1.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("bnz1.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("bnz1.E", 3'd2, BNZ | SGN | PCW | RW, 1'b1, 1'b0);

        set_instr(6'h18, 6'h00, 5'd0, 1'b0, 1'b0);
        step("bnz0.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("bnz0.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("bnz0.E", 3'd2, BNZ | SGN, 1'b1, 1'b0);

        set_instr(6'h18, 6'h00, 5'd5, 1'b0, 1'b1);
        step("ill.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("ill.D", 3'd1, 16'h0, 1'b1, 1'b1);

        set_instr(6'h00, 6'h00, 5'd0, 1'b0, 1'b0);
        step("nop.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("nop.D", 3'd1, 16'h0, 1'b1, 1'b0);
        step("after.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        chk("cnt15", retired_cnt, 32'd15);

        // Reset landing in sw's MEM cycle must suppress MemWrite and clear the counter.
        set_instr(6'h2b, 6'h00, 5'd0, 1'b0, 1'b0);
        step("swr.D", 3'd1, 16'h0, 1'b0, 1'b0);
        step("swr.E", 3'd2, ASRC | SGN, 1'b0, 1'b0);
        reset = 1'b1;
        step("swr.M", 3'd3, 16'h0, 1'b0, 1'b0);
        #1;
        chk("swr.state", {29'd0, state}, 32'd0);
        chk("swr.cnt", retired_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("swr.F", 3'd0, IRW | PCW, 1'b0, 1'b0);

        // Counter wrap: preload all-ones during a non-retiring cycle, then retire a nop.
        set_instr(6'h00, 6'h00, 5'd0, 1'b0, 1'b0);
        step("wrap.D0", 3'd1, 16'h0, 1'b1, 1'b0);
        force dut.retired_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_reg;
        chk("wrap.pre", retired_cnt, 32'hFFFF_FFFF);
        step("wrap.F", 3'd0, IRW | PCW, 1'b0, 1'b0);
        step("wrap.D", 3'd1, 16'h0, 1'b1, 1'b0);
        chk("wrap.cnt", retired_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
